// File: rtl/mux_rr_pkg.sv
// mux_rr_pkg: shared constants for the mux_rr channel multiplexer.
// Holds the mode encodings and the default channel geometry.
package mux_rr_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   localparam int DEF_WIDTH    = 32;
   localparam int DEF_CHANNELS = 4;

endpackage

// File: rtl/mux_rr_if.sv
// mux_rr_if: channel-side and output-side handshake bundle of mux_rr.
// slave is the multiplexer's view, master is the view of whatever drives it.
interface mux_rr_if
   import mux_rr_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int SELW     = $clog2(CHANNELS)
) ();

   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic [WIDTH-1:0]          out_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [SELW-1:0]           out_chan;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_chan
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_chan
   );

endinterface

// File: rtl/mux_rr_pick.sv
// rr_pick: rotating-priority picker. Returns the first requesting channel
// found when searching upward from (ptr+1) mod CHANNELS with wrap-around.
module rr_pick
   import mux_rr_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int SELW     = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req_i,
   input  logic [SELW-1:0]     ptr_i,
   output logic [SELW-1:0]     grant_o,
   output logic                grantValid_o
);

   // Walk candidates from farthest to nearest so the nearest requester wins last.
   always_comb begin
      grant_o      = '0;
      grantValid_o = 1'b0;
      for (int k = CHANNELS; k >= 1; k--) begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (req_i[c] && (((int'(ptr_i) + k) % CHANNELS) == c)) begin
               grant_o      = SELW'(c);
               grantValid_o = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mux_rr.sv
// mux_rr: N-channel to 1 multiplexer with fixed-select or round-robin
// arbitration feeding a single registered output stage.
// Optional feature macro: MUX_RR_STATS_EN adds a 16-bit transfer counter.
module mux_rr
   import mux_rr_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int SELW     = $clog2(CHANNELS)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            mode,
   input  logic [SELW-1:0] sel,
   mux_rr_if.slave         bus
`ifdef MUX_RR_STATS_EN
   ,
   output logic [15:0]     xfer_count
`endif
);

   logic [SELW-1:0]     ptr_q, ptr_d;
   logic [WIDTH-1:0]    outData_q, outData_d;
   logic                outValid_q, outValid_d;
   logic [SELW-1:0]     outChan_q, outChan_d;

   logic                accept;
   logic                fixedValid;
   logic                rrValid;
   logic [SELW-1:0]     rrGrant;
   logic [SELW-1:0]     grant;
   logic                grantValid;
   logic                xfer;
   logic [CHANNELS-1:0] inReady;
   logic [WIDTH-1:0]    grantData;

   rr_pick #(
      .CHANNELS (CHANNELS),
      .SELW     (SELW)
   ) u_pick (
      .req_i        (bus.in_valid),
      .ptr_i        (ptr_q),
      .grant_o      (rrGrant),
      .grantValid_o (rrValid)
   );

   // Fixed mode grants only an in-range sel whose channel is valid.
   always_comb begin
      fixedValid = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if ((sel == SELW'(c)) && bus.in_valid[c]) begin
            fixedValid = 1'b1;
         end
      end
   end

   // Choose the grant for the current mode and steer ready/data from it; reset blocks all readies.
   always_comb begin
      accept     = !outValid_q || bus.out_ready;
      grant      = (mode == MODE_RR) ? rrGrant : sel;
      grantValid = reset_n && ((mode == MODE_RR) ? rrValid : fixedValid);
      xfer       = accept && grantValid;
      inReady    = '0;
      grantData  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (grant == SELW'(c)) begin
            inReady[c] = xfer;
            grantData  = bus.in_data[c*WIDTH +: WIDTH];
         end
      end
   end

   // Next output-register and pointer state: load on transfer, drain when consumed.
   always_comb begin
      ptr_d      = ptr_q;
      outData_d  = outData_q;
      outValid_d = outValid_q;
      outChan_d  = outChan_q;
      if (xfer) begin
         outData_d  = grantData;
         outChan_d  = grant;
         outValid_d = 1'b1;
         if (mode == MODE_RR) begin
            ptr_d = grant;
         end
      end else if (outValid_q && bus.out_ready) begin
         outValid_d = 1'b0;
      end
   end

   // Output register and pointer; the pointer resets to the last channel so channel 0 goes first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q      <= SELW'(CHANNELS - 1);
         outData_q  <= '0;
         outValid_q <= 1'b0;
         outChan_q  <= '0;
      end else begin
         ptr_q      <= ptr_d;
         outData_q  <= outData_d;
         outValid_q <= outValid_d;
         outChan_q  <= outChan_d;
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.out_data  = outData_q;
   assign bus.out_valid = outValid_q;
   assign bus.out_chan  = outChan_q;

`ifdef MUX_RR_STATS_EN
   logic [15:0] xferCount_q;

   // Count every input transfer, wrapping naturally at 16 bits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         xferCount_q <= '0;
      end else if (xfer) begin
         xferCount_q <= xferCount_q + 16'd1;
      end
   end

   assign xfer_count = xferCount_q;
`endif

endmodule

// File: tb/tb_mux_rr.sv
// tb_mux_rr: self-checking bench for mux_rr with a behavioural model,
// directed scenarios pinned by literal values, and randomized traffic.
// Honours MUX_RR_STATS_EN when the design is built with it.
module tb_mux_rr;
   import mux_rr_pkg::*;

   localparam int WIDTH    = 32;
   localparam int CHANNELS = 4;
   localparam int SELW     = 3;

   logic            clk     = 1'b0;
   logic            reset_n = 1'b0;
   logic            mode    = MODE_FIXED;
   logic [SELW-1:0] sel     = '0;

   int checkCount = 0;
   int passCount  = 0;

   mux_rr_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SELW(SELW)) bus ();

`ifdef MUX_RR_STATS_EN
   logic [15:0] xfer_count;
`endif

   mux_rr #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS),
      .SELW     (SELW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .mode    (mode),
      .sel     (sel),
      .bus     (bus)
`ifdef MUX_RR_STATS_EN
      ,
      .xfer_count (xfer_count)
`endif
   );

   always #5 clk = ~clk;

   // One comparison: count it, and report it when it disagrees.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive the control and handshake inputs for the coming cycle.
   task automatic applyStimulus(input logic m, input logic [SELW-1:0] s, input logic [CHANNELS-1:0] v, input logic r);
      mode          = m;
      sel           = s;
      bus.in_valid  = v;
      bus.out_ready = r;
   endtask

   task automatic setPatternData();
      for (int c = 0; c < CHANNELS; c++) begin
         bus.in_data[c*WIDTH +: WIDTH] = 32'h1000_0000 + 32'(c);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   task automatic doReset();
      tick();
      reset_n = 1'b0;
      look();
      tick();
      reset_n = 1'b1;
   endtask

   // Behavioural model: output register contents, priority pointer, transfer count.
   logic        expValid;
   logic [31:0] expData;
   int          expChan;
   int          expPtr;
   logic [15:0] expCount;

   // Every negedge: predict ready from the rules, compare all outputs, then apply the coming edge.
   always @(negedge clk) begin : compareProc
      int g;
      int best;
      int d;
      int s;
      bit has;
      bit acc;
      logic [CHANNELS-1:0]       v;
      logic [CHANNELS-1:0]       expReady;
      logic [CHANNELS*WIDTH-1:0] allData;
      if (!reset_n) begin
         expValid = 1'b0;
         expData  = '0;
         expChan  = 0;
         expPtr   = CHANNELS - 1;
         expCount = '0;
      end
      v       = bus.in_valid;
      allData = bus.in_data;
      has     = 1'b0;
      g       = 0;
      if (reset_n) begin
         if (mode == MODE_RR) begin
            best = CHANNELS;
            for (int c = 0; c < CHANNELS; c++) begin
               d = (c - expPtr - 1 + 2 * CHANNELS) % CHANNELS;
               if (v[2'(c)] && d < best) begin
                  best = d;
                  g    = c;
                  has  = 1'b1;
               end
            end
         end else begin
            s = int'(sel);
            if (s < CHANNELS && v[2'(s)]) begin
               g   = s;
               has = 1'b1;
            end
         end
      end
      acc      = !expValid || bus.out_ready;
      expReady = (acc && has) ? 4'(1 << g) : 4'b0000;
      checkOutput("model_in_ready", 64'(bus.in_ready), 64'(expReady));
      checkOutput("model_out_valid", 64'(bus.out_valid), 64'(expValid));
      checkOutput("model_out_data", 64'(bus.out_data), 64'(expData));
      checkOutput("model_out_chan", 64'(bus.out_chan), 64'(expChan));
`ifdef MUX_RR_STATS_EN
      checkOutput("model_xfer_count", 64'(xfer_count), 64'(expCount));
`endif
      if (acc && has) begin
         expData  = allData[g*WIDTH +: WIDTH];
         expChan  = g;
         expValid = 1'b1;
         if (mode == MODE_RR) begin
            expPtr = g;
         end
         expCount = expCount + 16'd1;
      end else if (expValid && bus.out_ready) begin
         expValid = 1'b0;
      end
   end

   // Directed scenarios with literal expectations, then randomized traffic.
   initial begin
      bus.in_data   = '0;
      bus.in_valid  = '0;
      bus.out_ready = 1'b0;
      setPatternData();

      // Reset with every channel valid.
      applyStimulus(MODE_FIXED, 3'd0, 4'b1111, 1'b1);
      look();
      look();
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst_out_data", 64'(bus.out_data), 64'd0);
      checkOutput("rst_out_chan", 64'(bus.out_chan), 64'd0);
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'b0000);
      tick();
      reset_n = 1'b1;

      // Fixed select of channel 2.
      bus.in_data[2*WIDTH +: WIDTH] = 32'hA5A5_A5A5;
      applyStimulus(MODE_FIXED, 3'd2, 4'b0100, 1'b1);
      look();
      checkOutput("fix_in_ready", 64'(bus.in_ready), 64'b0100);
      look();
      checkOutput("fix_out_data", 64'(bus.out_data), 64'hA5A5_A5A5);
      checkOutput("fix_out_chan", 64'(bus.out_chan), 64'd2);
      checkOutput("fix_out_valid", 64'(bus.out_valid), 64'd1);

      // Reset between edges drops the held word at once.
      tick();
      reset_n = 1'b0;
      #1;
      checkOutput("async_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("async_out_data", 64'(bus.out_data), 64'd0);
      look();
      tick();
      reset_n = 1'b1;

      // Round-robin over four busy channels.
      setPatternData();
      applyStimulus(MODE_RR, 3'd0, 4'b1111, 1'b1);
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         look();
         checkOutput($sformatf("rr_seq_chan%0d", k), 64'(bus.out_chan), 64'(k % 4));
         checkOutput($sformatf("rr_seq_data%0d", k), 64'(bus.out_data), 64'(32'h1000_0000 + 32'(k % 4)));
      end

      // Backpressure holds the word and blocks every channel.
      tick();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         look();
         checkOutput("bp_in_ready", 64'(bus.in_ready), 64'b0000);
         checkOutput("bp_out_data", 64'(bus.out_data), 64'h1000_0000);
         checkOutput("bp_out_valid", 64'(bus.out_valid), 64'd1);
         tick();
      end
      bus.out_ready = 1'b1;
      look();
      checkOutput("bp_release_ready", 64'(bus.in_ready), 64'b0010);
      checkOutput("bp_release_chan", 64'(bus.out_chan), 64'd0);
      look();
      checkOutput("bp_next_chan", 64'(bus.out_chan), 64'd1);
      checkOutput("bp_next_data", 64'(bus.out_data), 64'h1000_0001);

      // Out-of-range sel never grants; lone ch3 in round-robin wraps around.
      doReset();
      applyStimulus(MODE_FIXED, 3'd5, 4'b1111, 1'b1);
      for (int k = 0; k < 3; k++) begin
         look();
         checkOutput("sel5_out_valid", 64'(bus.out_valid), 64'd0);
         checkOutput("sel5_in_ready", 64'(bus.in_ready), 64'b0000);
         tick();
      end
      applyStimulus(MODE_RR, 3'd0, 4'b1000, 1'b1);
      look();
      checkOutput("wrap_in_ready", 64'(bus.in_ready), 64'b1000);
      tick();
      look();
      checkOutput("wrap_chan_a", 64'(bus.out_chan), 64'd3);
      checkOutput("wrap_in_ready2", 64'(bus.in_ready), 64'b1000);
      tick();
      look();
      checkOutput("wrap_chan_b", 64'(bus.out_chan), 64'd3);

`ifdef MUX_RR_STATS_EN
      // Transfer counter: ten transfers, then an asynchronous clear.
      doReset();
      applyStimulus(MODE_RR, 3'd0, 4'b1111, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      applyStimulus(MODE_RR, 3'd0, 4'b0000, 1'b1);
      look();
      checkOutput("stats_count10", 64'(xfer_count), 64'd10);
      tick();
      applyStimulus(MODE_RR, 3'd0, 4'b1111, 1'b1);
      tick();
      reset_n = 1'b0;
      #1;
      checkOutput("stats_rst_count", 64'(xfer_count), 64'd0);
      checkOutput("stats_rst_valid", 64'(bus.out_valid), 64'd0);
      look();
      tick();
      reset_n = 1'b1;
`endif

      // Randomized traffic with occasional reset pulses, checked by the model.
      for (int n = 0; n < 600; n++) begin
         tick();
         if ($urandom_range(0, 7) == 0) begin
            mode = ~mode;
         end
         sel           = SELW'($urandom_range(0, 7));
         bus.in_valid  = CHANNELS'($urandom_range(0, 15));
         bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if (!reset_n) begin
            reset_n = 1'b1;
         end else if ($urandom_range(0, 49) == 0) begin
            reset_n = 1'b0;
         end
      end
      tick();
      reset_n = 1'b1;
      tick();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
